// File: rtl/signed_accumulator_if.sv
// Handshake/bus bundle for signed_accumulator.
//   master : producer/consumer side (drives start, in_valid, in_data, out_ready)
//   slave  : accumulator side (drives in_ready, out_valid, out_sum, out_ovf,
//            out_carry, busy)
interface signed_accumulator_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_ovf;
   logic             out_carry;
   logic             busy;

   modport master (
      output start, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_carry, busy
   );

   modport slave (
      input  start, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_carry, busy
   );
endinterface

// File: rtl/signed_accumulator.sv
// Frame accumulator placed after the signed ripple-carry adder: sums COUNT
// signed operands per frame (WIDTH-bit two's complement, carry-in 0), with
// optional clamp on signed overflow, a sticky overflow flag and the raw
// carry-out of the last add. The result is held until the consumer takes it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of signed_accumulator_if
//           start/in_valid/in_data/out_ready in,
//           in_ready/out_valid/out_sum/out_ovf/out_carry/busy out (registered)
module signed_accumulator #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned COUNT    = 4,
   parameter bit          SATURATE = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   signed_accumulator_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(COUNT + 1);
   localparam int unsigned MSB   = WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_acc, w_acc_nx;
   logic [CNT_W-1:0] r_count, w_count_nx;
   logic             r_ovf, w_ovf_nx;
   logic             r_carry, w_carry_nx;
   logic [WIDTH-1:0] r_out_sum, w_out_sum_nx;
   logic             r_out_ovf, w_out_ovf_nx;
   logic             r_out_carry, w_out_carry_nx;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic [WIDTH:0]   w_sum_ext;
   logic [WIDTH-1:0] w_raw;
   logic [WIDTH-1:0] w_sat;
   logic [WIDTH-1:0] w_add;
   logic             w_v;
   logic             w_accept;

   // Adder datapath: unsigned add with carry-in 0, signed overflow detect, clamp
   always_comb begin
      w_sum_ext = {1'b0, r_acc} + {1'b0, bus.in_data};
      w_raw     = w_sum_ext[WIDTH-1:0];
      w_v       = (r_acc[MSB] == bus.in_data[MSB]) && (w_raw[MSB] != r_acc[MSB]);
      // Clamp direction follows the pre-add sign (both operands share it on overflow)
      w_sat     = r_acc[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      w_add     = (w_v && SATURATE) ? w_sat : w_raw;
      w_accept  = bus.in_valid && r_in_ready && (r_state == S_ACCUM);
   end

   // Next-state and datapath register updates
   always_comb begin
      w_state_nx     = r_state;
      w_acc_nx       = r_acc;
      w_count_nx     = r_count;
      w_ovf_nx       = r_ovf;
      w_carry_nx     = r_carry;
      w_out_sum_nx   = r_out_sum;
      w_out_ovf_nx   = r_out_ovf;
      w_out_carry_nx = r_out_carry;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_acc_nx   = '0;
               w_count_nx = '0;
               w_ovf_nx   = 1'b0;
               w_carry_nx = 1'b0;
               w_state_nx = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (w_accept) begin
               w_acc_nx   = w_add;
               w_count_nx = r_count + CNT_W'(1);
               w_ovf_nx   = r_ovf | w_v;
               w_carry_nx = w_sum_ext[WIDTH];
               if (r_count == CNT_W'(COUNT - 1)) begin
                  w_out_sum_nx   = w_add;
                  w_out_ovf_nx   = r_ovf | w_v;
                  w_out_carry_nx = w_sum_ext[WIDTH];
                  w_state_nx     = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; handshake flags decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_carry     <= 1'b0;
         r_out_sum   <= '0;
         r_out_ovf   <= 1'b0;
         r_out_carry <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_acc       <= w_acc_nx;
         r_count     <= w_count_nx;
         r_ovf       <= w_ovf_nx;
         r_carry     <= w_carry_nx;
         r_out_sum   <= w_out_sum_nx;
         r_out_ovf   <= w_out_ovf_nx;
         r_out_carry <= w_out_carry_nx;
         r_in_ready  <= (w_state_nx == S_ACCUM);
         r_out_valid <= (w_state_nx == S_DONE);
         r_busy      <= (w_state_nx != S_IDLE);
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_ovf   = r_out_ovf;
   assign bus.out_carry = r_out_carry;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_signed_accumulator.sv
// Bench for signed_accumulator: a saturating and a wrapping instance share the
// same stimulus; a reference model pushes expected frame results to queues.
module tb_signed_accumulator;

   typedef struct packed {
      logic [7:0] sum;
      logic       ovf;
      logic       carry;
   } res_t;

   logic clk;
   logic rst_n;
   logic start;
   logic in_valid;
   logic [7:0] in_data;
   logic out_ready;

   int pass_cnt  = 0;
   int total_cnt = 0;

   res_t q_s[$];
   res_t q_w[$];

   int m_acc_s, m_acc_w, m_cnt;
   bit m_ovf_s, m_ovf_w, m_carry_s, m_carry_w;

   signed_accumulator_if #(.WIDTH(8)) ifc_s ();
   signed_accumulator_if #(.WIDTH(8)) ifc_w ();

   assign ifc_s.start     = start;
   assign ifc_s.in_valid  = in_valid;
   assign ifc_s.in_data   = in_data;
   assign ifc_s.out_ready = out_ready;
   assign ifc_w.start     = start;
   assign ifc_w.in_valid  = in_valid;
   assign ifc_w.in_data   = in_data;
   assign ifc_w.out_ready = out_ready;

   signed_accumulator #(.WIDTH(8), .COUNT(4), .SATURATE(1'b1)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc_s)
   );

   signed_accumulator #(.WIDTH(8), .COUNT(4), .SATURATE(1'b0)) u_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference: signed integer add, overflow when the true sum leaves [-128,127]
   function automatic void acc_step(input bit sat, input int d, inout int acc,
                                    inout bit ovf, inout bit carry);
      int s;
      s     = acc + d;
      carry = (((acc & 255) + (d & 255)) > 255);
      if (s > 127 || s < -128) begin
         ovf = 1'b1;
         if (sat) s = (s > 127) ? 127 : -128;
         else     s = (s > 127) ? s - 256 : s + 256;
      end
      acc = s;
   endfunction

   function automatic res_t obs_s();
      return {ifc_s.out_sum, ifc_s.out_ovf, ifc_s.out_carry};
   endfunction

   function automatic res_t obs_w();
      return {ifc_w.out_sum, ifc_w.out_ovf, ifc_w.out_carry};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      m_acc_s = 0; m_acc_w = 0; m_cnt = 0;
      m_ovf_s = 0; m_ovf_w = 0; m_carry_s = 0; m_carry_w = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // One accepted operand; the model pushes the frame result on the last one
   task automatic send(input int d);
      in_valid = 1'b1;
      in_data  = 8'(d);
      acc_step(1'b1, d, m_acc_s, m_ovf_s, m_carry_s);
      acc_step(1'b0, d, m_acc_w, m_ovf_w, m_carry_w);
      m_cnt++;
      if (m_cnt == 4) begin
         q_s.push_back({8'(m_acc_s), m_ovf_s, m_carry_s});
         q_w.push_back({8'(m_acc_w), m_ovf_w, m_carry_w});
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ifc_s.out_valid && ifc_w.out_valid) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic pop_exp(output res_t es, output res_t ew);
      es = 'x;
      ew = 'x;
      if (q_s.size() > 0) es = q_s.pop_front();
      if (q_w.size() > 0) ew = q_w.pop_front();
   endtask

   task automatic test_reset();
      logic [12:0] o;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) tick();
      o = {ifc_s.in_ready, ifc_s.out_valid, ifc_s.busy, obs_s()};
      total_cnt++;
      if (o !== 13'd0) $display("FAIL reset_sat: got %h want 0", o); else pass_cnt++;
      o = {ifc_w.in_ready, ifc_w.out_valid, ifc_w.busy, obs_w()};
      total_cnt++;
      if (o !== 13'd0) $display("FAIL reset_wrap: got %h want 0", o); else pass_cnt++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      res_t es, ew;
      bit ok;
      start_frame();
      total_cnt++;
      if ({ifc_s.busy, ifc_s.in_ready, ifc_s.out_valid} !== 3'b110)
         $display("FAIL basic_accum_flags: got %b want 110",
                  {ifc_s.busy, ifc_s.in_ready, ifc_s.out_valid});
      else pass_cnt++;
      send(50); send(10); send(-5);
      total_cnt++;
      if ({ifc_s.out_valid, ifc_w.out_valid} !== 2'b00)
         $display("FAIL basic_early_valid: got %b want 00", {ifc_s.out_valid, ifc_w.out_valid});
      else pass_cnt++;
      send(-20);
      total_cnt++;
      if ({ifc_s.out_valid, ifc_w.out_valid, ifc_s.in_ready} !== 3'b110)
         $display("FAIL basic_latency: got %b want 110",
                  {ifc_s.out_valid, ifc_w.out_valid, ifc_s.in_ready});
      else pass_cnt++;
      wait_out(ok);
      pop_exp(es, ew);
      total_cnt++;
      if (obs_s() !== es || !ok) $display("FAIL basic_sat: got %h want %h", obs_s(), es);
      else pass_cnt++;
      total_cnt++;
      if (obs_w() !== ew || !ok) $display("FAIL basic_wrap: got %h want %h", obs_w(), ew);
      else pass_cnt++;
      total_cnt++;
      if (obs_s() !== {8'd35, 1'b0, 1'b1}) $display("FAIL basic_const: got %h want %h", obs_s(), {8'd35, 2'b01});
      else pass_cnt++;
      consume();
      total_cnt++;
      if ({ifc_s.out_valid, ifc_s.busy, ifc_w.out_valid, ifc_w.busy} !== 4'b0000)
         $display("FAIL basic_release: got %b want 0000",
                  {ifc_s.out_valid, ifc_s.busy, ifc_w.out_valid, ifc_w.busy});
      else pass_cnt++;
   endtask

   task automatic test_saturation(input int a, input int b, input string nm);
      res_t es, ew;
      bit ok;
      start_frame();
      send(a); send(b); send(0); send(0);
      wait_out(ok);
      pop_exp(es, ew);
      total_cnt++;
      if (obs_s() !== es || !ok) $display("FAIL %s_sat: got %h want %h", nm, obs_s(), es);
      else pass_cnt++;
      total_cnt++;
      if (obs_w() !== ew || !ok) $display("FAIL %s_wrap: got %h want %h", nm, obs_w(), ew);
      else pass_cnt++;
      consume();
   endtask

   task automatic test_gaps_backpressure();
      res_t es, ew;
      bit ok;
      int ops[4] = '{127, -100, 0, 0};
      start_frame();
      foreach (ops[i]) begin
         send(ops[i]);
         if (i < 3) repeat (3) tick();
      end
      wait_out(ok);
      es = (q_s.size() > 0) ? q_s[0] : 'x;
      for (int c = 0; c < 5; c++) begin
         total_cnt++;
         if (!ok || obs_s() !== es || ifc_s.out_valid !== 1'b1)
            $display("FAIL hold_cycle%0d: got %h/%b want %h/1", c, obs_s(), ifc_s.out_valid, es);
         else pass_cnt++;
         tick();
      end
      pop_exp(es, ew);
      total_cnt++;
      if (obs_w() !== ew) $display("FAIL gaps_wrap: got %h want %h", obs_w(), ew);
      else pass_cnt++;
      consume();
      total_cnt++;
      if ({ifc_s.busy, ifc_s.out_valid, obs_s()} !== {2'b00, 8'd27, 2'b00})
         $display("FAIL gaps_idle_hold: got %h want %h", {ifc_s.busy, ifc_s.out_valid, obs_s()},
                  {2'b00, 8'd27, 2'b00});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      res_t es, ew;
      bit ok;
      logic [12:0] o;
      start_frame();
      send(5); send(7);
      rst_n = 1'b0;
      #2;
      o = {ifc_s.in_ready, ifc_s.out_valid, ifc_s.busy, obs_s()};
      total_cnt++;
      if (o !== 13'd0) $display("FAIL midreset_sat: got %h want 0", o); else pass_cnt++;
      o = {ifc_w.in_ready, ifc_w.out_valid, ifc_w.busy, obs_w()};
      total_cnt++;
      if (o !== 13'd0) $display("FAIL midreset_wrap: got %h want 0", o); else pass_cnt++;
      tick();
      rst_n = 1'b1;
      tick();
      total_cnt++;
      if (ifc_s.out_valid !== 1'b0) $display("FAIL midreset_no_emit: got %b want 0", ifc_s.out_valid);
      else pass_cnt++;
      start_frame();
      send(1); send(1); send(1); send(1);
      wait_out(ok);
      pop_exp(es, ew);
      total_cnt++;
      if (obs_s() !== es || !ok) $display("FAIL midreset_frame: got %h want %h", obs_s(), es);
      else pass_cnt++;
      consume();
   endtask

   task automatic test_ignored();
      res_t es, ew;
      bit ok;
      start_frame();
      send(10);
      pulse_start();
      send(10); send(10);
      pulse_start();
      total_cnt++;
      if (ifc_s.out_valid !== 1'b0) $display("FAIL ign_count: got %b want 0", ifc_s.out_valid);
      else pass_cnt++;
      send(10);
      wait_out(ok);
      pulse_start();
      es = (q_s.size() > 0) ? q_s[0] : 'x;
      total_cnt++;
      if (!ok || ifc_s.out_valid !== 1'b1 || obs_s() !== es)
         $display("FAIL ign_done_start: got %h/%b want %h/1", obs_s(), ifc_s.out_valid, es);
      else pass_cnt++;
      pop_exp(es, ew);
      total_cnt++;
      if (obs_w() !== ew) $display("FAIL ign_frame_wrap: got %h want %h", obs_w(), ew);
      else pass_cnt++;
      // start coincident with the output handshake must not open a frame
      start = 1'b1;
      consume();
      start = 1'b0;
      tick();
      total_cnt++;
      if ({ifc_s.busy, ifc_s.in_ready} !== 2'b00)
         $display("FAIL ign_handshake_start: got %b want 00", {ifc_s.busy, ifc_s.in_ready});
      else pass_cnt++;
      in_valid = 1'b1;
      in_data  = 8'd99;
      repeat (2) tick();
      total_cnt++;
      if ({ifc_s.in_ready, ifc_s.busy, ifc_s.out_valid} !== 3'b000)
         $display("FAIL ign_idle_valid: got %b want 000", {ifc_s.in_ready, ifc_s.busy, ifc_s.out_valid});
      else pass_cnt++;
      in_valid = 1'b0;
      start_frame();
      send(10); send(10); send(10); send(10);
      wait_out(ok);
      pop_exp(es, ew);
      total_cnt++;
      if (obs_s() !== es || !ok || ifc_s.out_sum !== 8'd40)
         $display("FAIL ign_next_frame: got %h want %h", obs_s(), es);
      else pass_cnt++;
      consume();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation(50, 100, "pos");
      test_saturation(-50, -100, "neg");
      test_gaps_backpressure();
      test_reset_mid();
      test_ignored();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
